// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings and default width.
package div_pkg;

  localparam int DIV_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_seq_restoring_addsub_ripple.sv
// Ripple-carry adder/subtractor: s = a + (b ^ {N{sub}}) + sub, with carry-out.
module addsub_ripple #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0]   carry;
  logic [N-1:0] b_eff;

  assign b_eff    = b ^ {N{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s[i]       = a[i] ^ b_eff[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/div_seq_restoring.sv
// Sequential restoring divider: one quotient bit per RUN cycle, fixed latency,
// divide-by-zero short-circuits straight to DONE.
module div_seq_restoring
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  div_state_e  state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [W:0]    r_q, r_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  divisor_q, divisor_d;
  logic [W-1:0]  quotient_q, quotient_d;
  logic [W-1:0]  remainder_q, remainder_d;
  logic          dbz_q, dbz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [W:0] r_sh;
  logic [W:0] trial;
  logic       no_borrow;

  // Shift {R,Q} left by one; the bit leaving Q enters the bottom of R.
  assign r_sh = {r_q[W-1:0], q_q[W-1]};

  addsub_ripple #(.N(W + 1)) u_trial (
    .a    (r_sh),
    .b    ({1'b0, divisor_q}),
    .sub  (1'b1),
    .s    (trial),
    .cout (no_borrow)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    r_d         = r_q;
    q_d         = q_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            q_d       = dividend;
            r_d       = '0;
            count_d   = '0;
            divisor_d = divisor;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        // W shift/subtract steps, then one cycle to publish the result.
        if (count_q == CW'(W)) begin
          quotient_d  = q_q;
          remainder_d = r_q[W-1:0];
          dbz_d       = 1'b0;
          state_d     = DONE;
        end else begin
          r_d     = no_borrow ? trial : r_sh;
          q_d     = {q_q[W-2:0], no_borrow};
          count_d = count_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      r_q         <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      r_q         <= r_d;
      q_q         <= q_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_restoring.sv
// Directed self-checking bench for div_seq_restoring: latency, divide-by-zero,
// dropped restarts, mid-operation reset and a full 4-bit operand sweep.
module tb_div_seq_restoring;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_asserts = 0;
  int n_fails   = 0;

  div_seq_restoring #(.W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the sampling edge.
  task automatic applyStimulus(input logic [3:0] dd, input logic [3:0] dv);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output bit found);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (done === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic runOp(input string tag, input logic [3:0] dd, input logic [3:0] dv,
                       input logic [3:0] exp_q, input logic [3:0] exp_r,
                       input logic exp_dbz);
    bit found;
    applyStimulus(dd, dv);
    waitDone(found);
    checkOutput({tag, "_done_seen"}, found, 1);
    checkOutput({tag, "_q"}, quotient, exp_q);
    checkOutput({tag, "_r"}, remainder, exp_r);
    checkOutput({tag, "_dbz"}, div_by_zero, exp_dbz);
    @(negedge clk);
  endtask

  initial begin
    int  done_count;
    logic [3:0] cap_q, cap_r;
    bit  saw_done;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_q", quotient, 0);
    checkOutput("reset_r", remainder, 0);
    checkOutput("reset_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] 13/3 latency check");
    applyStimulus(4'd13, 4'd3);
    checkOutput("lat_busy_run", busy, 1);
    repeat (4) @(negedge clk);
    checkOutput("lat_done_early", done, 0);
    @(negedge clk);
    checkOutput("lat_done_edge5", done, 1);
    checkOutput("lat_q", quotient, 4);
    checkOutput("lat_r", remainder, 1);
    checkOutput("lat_dbz", div_by_zero, 0);
    @(negedge clk);
    checkOutput("lat_done_pulse", done, 0);
    checkOutput("lat_busy_idle", busy, 0);

    $display("[TB] 9/0 divide by zero");
    applyStimulus(4'd9, 4'd0);
    checkOutput("dbz_done", done, 1);
    checkOutput("dbz_busy", busy, 1);
    checkOutput("dbz_q", quotient, 15);
    checkOutput("dbz_r", remainder, 9);
    checkOutput("dbz_flag", div_by_zero, 1);
    @(negedge clk);
    checkOutput("dbz_busy_low", busy, 0);
    checkOutput("dbz_done_low", done, 0);

    runOp("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    runOp("d3_7", 4'd3, 4'd7, 4'd0, 4'd3, 1'b0);

    $display("[TB] 14/4 with dropped restart");
    applyStimulus(4'd14, 4'd4);
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd2;
    @(negedge clk);
    start      = 1'b0;
    done_count = 0;
    cap_q      = '0;
    cap_r      = '0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        done_count++;
        cap_q = quotient;
        cap_r = remainder;
      end
      @(negedge clk);
    end
    checkOutput("restart_done_count", done_count, 1);
    checkOutput("restart_q", cap_q, 3);
    checkOutput("restart_r", cap_r, 2);
    checkOutput("restart_busy_idle", busy, 0);
    checkOutput("restart_q_held", quotient, 3);

    $display("[TB] 12/5 with mid-run reset");
    applyStimulus(4'd12, 4'd5);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_q", quotient, 0);
    checkOutput("midrst_r", remainder, 0);
    checkOutput("midrst_dbz", div_by_zero, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    checkOutput("midrst_no_done", saw_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    runOp("after_rst", 4'd12, 4'd5, 4'd2, 4'd2, 1'b0);

    $display("[TB] exhaustive sweep");
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) runOp($sformatf("sw_%0d_%0d", a, b), 4'(a), 4'(b), 4'd15, 4'(a), 1'b1);
        else        runOp($sformatf("sw_%0d_%0d", a, b), 4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
